// File: rtl/dual_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// dual_fetch_queue_if
// Bundles the fetch-side and decode-side signals of the dual fetch queue.
//   master : fetch unit / decode stage side (drives fetch_*, flush, dec_ready)
//   slave  : the queue itself (drives fetch_ready, instruction1/2, pc1/2,
//            ins1_valid/ins2_valid, count)
// Signals:
//   flush                  synchronous clear of all queued entries
//   fetch_valid1/2         fetch slot valids (slot 2 only honoured with slot 1)
//   fetch_ins1/2, fetch_pc fetched instructions and slot-1 PC
//   fetch_ready            queue can take a two-wide fetch this cycle
//   dec_ready              decode consumes every presented valid slot
//   instruction1/2, pc1/2  two oldest entries (zero when not valid)
//   ins1_valid/ins2_valid  presented-slot valids
//   count                  current occupancy
// ----------------------------------------------------------------------------
interface dual_fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int PCW   = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            fetch_valid1;
    logic            fetch_valid2;
    logic [XLEN-1:0] fetch_ins1;
    logic [XLEN-1:0] fetch_ins2;
    logic [PCW-1:0]  fetch_pc;
    logic            fetch_ready;
    logic            dec_ready;
    logic [XLEN-1:0] instruction1;
    logic [XLEN-1:0] instruction2;
    logic            ins1_valid;
    logic            ins2_valid;
    logic [PCW-1:0]  pc1;
    logic [PCW-1:0]  pc2;
    logic [CW-1:0]   count;

    modport master (
        output flush, fetch_valid1, fetch_valid2, fetch_ins1, fetch_ins2,
               fetch_pc, dec_ready,
        input  fetch_ready, instruction1, instruction2, ins1_valid,
               ins2_valid, pc1, pc2, count
    );

    modport slave (
        input  flush, fetch_valid1, fetch_valid2, fetch_ins1, fetch_ins2,
               fetch_pc, dec_ready,
        output fetch_ready, instruction1, instruction2, ins1_valid,
               ins2_valid, pc1, pc2, count
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// ----------------------------------------------------------------------------
// dual_fetch_queue
// Two-wide in-order instruction buffer between fetch and decode/dispatch.
// Accepts up to two {instruction, pc} pairs per cycle and presents the two
// oldest entries. Decouples fetch from decode stalls; flush clears the queue.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   q_if  slave modport of dual_fetch_queue_if (fetch and decode signals)
// ----------------------------------------------------------------------------
module dual_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int PCW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dual_fetch_queue_if.slave    q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [PCW-1:0]  pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          fetch_ready;
    logic          ins1_valid;
    logic          ins2_valid;
    logic [1:0]    enq_n;
    logic [1:0]    deq_n;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    entry_t        rd1;
    entry_t        rd2;

    // Pointer +1 wraps naturally because DEPTH is a power of two.
    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);
    assign rd1     = mem_q[head_q];
    assign rd2     = mem_q[head_p1];

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        // Registered count only: a same-cycle dequeue is not credited, which
        // keeps dec_ready off the fetch_ready path.
        fetch_ready = (count_q <= CW'(DEPTH - 2)) && !q_if.flush;
        ins1_valid  = (count_q >= CW'(1)) && !q_if.flush;
        ins2_valid  = (count_q >= CW'(2)) && !q_if.flush;

        enq_n = 2'd0;
        if (fetch_ready && q_if.fetch_valid1) begin
            enq_n = q_if.fetch_valid2 ? 2'd2 : 2'd1;
        end

        deq_n = 2'd0;
        if (q_if.dec_ready) begin
            deq_n = {1'b0, ins1_valid} + {1'b0, ins2_valid};
        end

        head_d  = head_q + AW'(deq_n);
        tail_d  = tail_q + AW'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(deq_n);

        if (q_if.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; stale contents are never visible because outputs are gated by count.
    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) begin
            mem_q[tail_q] <= '{ins: q_if.fetch_ins1, pc: q_if.fetch_pc};
        end
        if (enq_n == 2'd2) begin
            // Slot 2 PC wraps modulo 2^PCW.
            mem_q[tail_p1] <= '{ins: q_if.fetch_ins2, pc: q_if.fetch_pc + PCW'(4)};
        end
    end

    assign q_if.fetch_ready  = fetch_ready;
    assign q_if.ins1_valid   = ins1_valid;
    assign q_if.ins2_valid   = ins2_valid;
    assign q_if.instruction1 = ins1_valid ? rd1.ins : '0;
    assign q_if.pc1          = ins1_valid ? rd1.pc  : '0;
    assign q_if.instruction2 = ins2_valid ? rd2.ins : '0;
    assign q_if.pc2          = ins2_valid ? rd2.pc  : '0;
    assign q_if.count        = count_q;
endmodule
